// File: rtl/vscale_pc_redirect_ctrl_if.sv
// PC redirect control bundle: fetch/pipeline requests in, PC mux
// select, squash/stall controls and redirect counter out.
interface vscale_pc_redirect_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             imem_wait;
  logic             trap_req;
  logic             eret_req;
  logic             jal_DX;
  logic             jalr_DX;
  logic             branch_taken_DX;
  logic [2:0]       PC_src_sel;
  logic             kill_IF;
  logic             kill_DX;
  logic             stall_DX;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output imem_wait, trap_req, eret_req,
    output jal_DX, jalr_DX, branch_taken_DX,
    input  PC_src_sel, kill_IF, kill_DX,
    input  stall_DX, redirect_count
  );

  modport slave (
    input  imem_wait, trap_req, eret_req,
    input  jal_DX, jalr_DX, branch_taken_DX,
    output PC_src_sel, kill_IF, kill_DX,
    output stall_DX, redirect_count
  );
endinterface

// File: rtl/vscale_pc_redirect_ctrl.sv
// PC source scheduler: arbitrates trap/eret/DX redirects against
// fetch wait, holds blocked redirects and drains DX after traps.
module vscale_pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic reset,
  vscale_pc_redirect_ctrl_if.slave bus
);

  localparam logic [2:0] PC_PLUS_FOUR     = 3'd0;
  localparam logic [2:0] PC_BRANCH_TARGET = 3'd1;
  localparam logic [2:0] PC_JAL_TARGET    = 3'd2;
  localparam logic [2:0] PC_JALR_TARGET   = 3'd3;
  localparam logic [2:0] PC_REPLAY        = 3'd4;
  localparam logic [2:0] PC_HANDLER       = 3'd5;
  localparam logic [2:0] PC_EPC           = 3'd6;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [2:0]       flush_cnt, flush_n;
  logic [2:0]       pend_sel, pend_n;
  logic [CNT_W-1:0] count;

  logic [2:0] sel;
  logic       kill_if, kill_dx, stall;
  logic       dx_redir;
  logic [2:0] dx_sel;
  logic       is_redir;

  assign dx_redir = bus.jalr_DX | bus.jal_DX
                  | bus.branch_taken_DX;

  always_comb begin
    dx_sel = PC_BRANCH_TARGET;
    if (bus.jalr_DX)     dx_sel = PC_JALR_TARGET;
    else if (bus.jal_DX) dx_sel = PC_JAL_TARGET;
  end

  always_comb begin
    sel     = PC_PLUS_FOUR;
    kill_if = 1'b0;
    kill_dx = 1'b0;
    stall   = 1'b0;
    state_n = state;
    flush_n = flush_cnt;
    pend_n  = pend_sel;
    case (state)
      S_RUN, S_PEND: begin
        if (bus.trap_req) begin
          sel     = PC_HANDLER;
          kill_if = 1'b1;
          kill_dx = 1'b1;
          state_n = S_FLUSH;
          flush_n = FLUSH_INIT;
          pend_n  = PC_PLUS_FOUR;
        end else if (bus.eret_req) begin
          sel     = PC_EPC;
          kill_if = 1'b1;
          kill_dx = 1'b1;
          state_n = S_RUN;
          pend_n  = PC_PLUS_FOUR;
        end else if (state == S_PEND) begin
          if (bus.imem_wait) begin
            sel   = PC_REPLAY;
            stall = 1'b1;
          end else begin
            sel     = pend_sel;
            kill_if = 1'b1;
            state_n = S_RUN;
          end
        end else if (dx_redir) begin
          if (bus.imem_wait) begin
            // hold DX so the target operands stay valid
            sel     = PC_REPLAY;
            stall   = 1'b1;
            pend_n  = dx_sel;
            state_n = S_PEND;
          end else begin
            sel     = dx_sel;
            kill_if = 1'b1;
          end
        end else if (bus.imem_wait) begin
          sel = PC_REPLAY;
        end
      end
      S_FLUSH: begin
        kill_dx = 1'b1;
        sel     = bus.imem_wait ? PC_REPLAY
                                : PC_PLUS_FOUR;
        if (bus.trap_req) begin
          sel     = PC_HANDLER;
          kill_if = 1'b1;
          flush_n = FLUSH_INIT;
        end else if (flush_cnt == 3'd0) begin
          state_n = S_RUN;
        end else begin
          flush_n = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_n = S_RUN;
        flush_n = 3'd0;
        pend_n  = PC_PLUS_FOUR;
      end
    endcase
    if (!reset) begin
      sel     = PC_REPLAY;
      kill_if = 1'b1;
      kill_dx = 1'b1;
      stall   = 1'b0;
    end
  end

  assign is_redir = (sel == PC_HANDLER)
                  | (sel == PC_EPC)
                  | (sel == PC_JAL_TARGET)
                  | (sel == PC_JALR_TARGET)
                  | (sel == PC_BRANCH_TARGET);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_RUN;
      flush_cnt <= 3'd0;
      pend_sel  <= PC_PLUS_FOUR;
      count     <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_n;
      pend_sel  <= pend_n;
      if (is_redir && (count != '1))
        count <= count + CNT_W'(1);
    end
  end

  assign bus.PC_src_sel     = sel;
  assign bus.kill_IF        = kill_if;
  assign bus.kill_DX        = kill_dx;
  assign bus.stall_DX       = stall;
  assign bus.redirect_count = count;

endmodule

// File: tb/tb_vscale_pc_redirect_ctrl.sv
// Bench for vscale_pc_redirect_ctrl: directed vector table, random
// stimulus against a rule-level model, counter saturation sequence.
module tb_vscale_pc_redirect_ctrl;

  localparam int P4 = 0, BR = 1, JAL = 2, JALR = 3;
  localparam int REP = 4, HND = 5, EPC = 6;
  localparam int RUN = 0, PEND = 1, FLSH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vscale_pc_redirect_ctrl_if #(.CNT_W(3))  ifa ();
  vscale_pc_redirect_ctrl_if #(.CNT_W(32)) ifb ();

  vscale_pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  vscale_pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    bit rst, wt, trap, eret, jal, jalr, br;
  } in_t;
  typedef struct {
    int sel; bit kif, kdx, stl;
  } out_t;
  typedef struct {
    int mode; int pend; int left; longint cnt;
  } mst_t;
  typedef struct {
    in_t i; out_t o; int cnt;
  } vec_t;

  int checks = 0;
  int failures = 0;
  mst_t ma, mb, na, nb;
  out_t act_a;
  longint act_cnt_a, act_cnt_b;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Rule-level reference: decide the PC source from priorities,
  // then advance the abstract mode.
  function automatic void model(input mst_t s, input in_t i,
      input int fc, input longint cmax,
      output out_t o, output mst_t n);
    int dx;
    n = s;
    o = '{P4, 1'b0, 1'b0, 1'b0};
    if (!i.rst) begin
      o = '{REP, 1'b1, 1'b1, 1'b0};
      n = '{RUN, P4, 0, 0};
      return;
    end
    dx = i.jalr ? JALR : i.jal ? JAL : i.br ? BR : -1;
    if (s.mode == FLSH) begin
      o.kdx = 1; o.sel = i.wt ? REP : P4;
      if (i.trap) begin
        o.sel = HND; o.kif = 1; n.left = fc - 1;
      end else if (s.left == 0) n.mode = RUN;
      else n.left = s.left - 1;
    end else if (i.trap) begin
      o = '{HND, 1'b1, 1'b1, 1'b0};
      n.mode = FLSH; n.left = fc - 1;
    end else if (i.eret) begin
      o = '{EPC, 1'b1, 1'b1, 1'b0};
      n.mode = RUN;
    end else if (s.mode == PEND) begin
      if (i.wt) o = '{REP, 1'b0, 1'b0, 1'b1};
      else begin
        o = '{s.pend, 1'b1, 1'b0, 1'b0}; n.mode = RUN;
      end
    end else if (dx >= 0) begin
      if (i.wt) begin
        o = '{REP, 1'b0, 1'b0, 1'b1};
        n.mode = PEND; n.pend = dx;
      end else o = '{dx, 1'b1, 1'b0, 1'b0};
    end else if (i.wt) o.sel = REP;
    if (o.sel inside {BR, JAL, JALR, HND, EPC} && s.cnt < cmax)
      n.cnt = s.cnt + 1;
  endfunction

  task automatic drive(input in_t i);
    reset = i.rst;
    ifa.imem_wait = i.wt;  ifb.imem_wait = i.wt;
    ifa.trap_req = i.trap; ifb.trap_req = i.trap;
    ifa.eret_req = i.eret; ifb.eret_req = i.eret;
    ifa.jal_DX = i.jal;    ifb.jal_DX = i.jal;
    ifa.jalr_DX = i.jalr;  ifb.jalr_DX = i.jalr;
    ifa.branch_taken_DX = i.br;
    ifb.branch_taken_DX = i.br;
  endtask

  task automatic step(input in_t i, input string tag);
    out_t oa, ob;
    drive(i);
    @(negedge clk);
    model(ma, i, 2, 7, oa, na);
    model(mb, i, 1, 64'hFFFF_FFFF, ob, nb);
    act_a = '{int'(ifa.PC_src_sel), ifa.kill_IF,
              ifa.kill_DX, ifa.stall_DX};
    act_cnt_a = longint'(ifa.redirect_count);
    act_cnt_b = longint'(ifa.redirect_count) * 0
              + longint'(ifb.redirect_count);
    chk({tag, " a.sel"}, act_a.sel, oa.sel);
    chk({tag, " a.kill_IF"}, act_a.kif, oa.kif);
    chk({tag, " a.kill_DX"}, act_a.kdx, oa.kdx);
    chk({tag, " a.stall_DX"}, act_a.stl, oa.stl);
    chk({tag, " a.count"}, act_cnt_a, ma.cnt);
    chk({tag, " b.sel"}, ifb.PC_src_sel, ob.sel);
    chk({tag, " b.kill_IF"}, ifb.kill_IF, ob.kif);
    chk({tag, " b.kill_DX"}, ifb.kill_DX, ob.kdx);
    chk({tag, " b.stall_DX"}, ifb.stall_DX, ob.stl);
    chk({tag, " b.count"}, act_cnt_b, mb.cnt);
    @(posedge clk);
    ma = na; mb = nb;
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit wt, bit trap, bit eret,
      bit jal, bit jalr, bit br, int sel, bit kif, bit kdx, bit stl,
      int cnt);
    vec_t v;
    v.i = '{rst, wt, trap, eret, jal, jalr, br};
    v.o = '{sel, kif, kdx, stl};
    v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t ri;
    //            rs wt tr er jl jr br  sel kI kD st cnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, REP, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, REP, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, BR,  1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, REP, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, REP, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, REP, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, JALR,1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, REP, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, HND, 1, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, P4,  0, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, P4,  0, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, HND, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, P4,  0, 1, 0, 4));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, REP, 0, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, EPC, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 5));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, HND, 1, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 1, 0, 6));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, HND, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 1, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 1, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, JAL, 1, 0, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, REP, 1, 1, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, REP, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, REP, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, JALR,1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, JAL, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, EPC, 1, 1, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, REP, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, REP, 0, 0, 1, 3));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, EPC, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P4,  0, 0, 0, 4));

    drive('{0, 0, 0, 0, 0, 0, 0});
    ma = '{RUN, P4, 0, 0};
    mb = '{RUN, P4, 0, 0};
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      step(tbl[k].i, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d tbl.sel", k), act_a.sel, tbl[k].o.sel);
      chk($sformatf("vec%0d tbl.kill_IF", k), act_a.kif, tbl[k].o.kif);
      chk($sformatf("vec%0d tbl.kill_DX", k), act_a.kdx, tbl[k].o.kdx);
      chk($sformatf("vec%0d tbl.stall", k), act_a.stl, tbl[k].o.stl);
      chk($sformatf("vec%0d tbl.count", k), act_cnt_a, tbl[k].cnt);
    end

    for (int n = 0; n < 600; n++) begin
      ri.rst  = $urandom_range(0, 99) >= 3;
      ri.wt   = $urandom_range(0, 2) == 0;
      ri.trap = $urandom_range(0, 15) == 0;
      ri.eret = $urandom_range(0, 11) == 0;
      ri.jal  = $urandom_range(0, 5) == 0;
      ri.jalr = $urandom_range(0, 5) == 0;
      ri.br   = $urandom_range(0, 5) == 0;
      step(ri, $sformatf("rnd%0d", n));
    end

    step('{0, 0, 0, 0, 0, 0, 0}, "sat_rst");
    for (int n = 0; n < 9; n++)
      step('{1, 0, 0, 0, 1, 0, 0}, $sformatf("sat_jal%0d", n));
    step('{1, 0, 0, 0, 0, 0, 0}, "sat_idle");
    chk("sat a.count", act_cnt_a, 7);
    chk("sat b.count", act_cnt_b, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
